// File: rtl/updown_btn_ctrl_if.sv
// Button-side bus for updown_btn_ctrl: raw pushbuttons in, direction level and event pulses out.
// The slave modport is the controller's view; master is the driver/observer side.
interface updown_btn_ctrl_if;
    logic btn_up;
    logic btn_down;
    logic up_down;
    logic up_evt;
    logic dn_evt;
    logic dir_chg;
    logic conflict;

    modport master (
        output btn_up,
        output btn_down,
        input  up_down,
        input  up_evt,
        input  dn_evt,
        input  dir_chg,
        input  conflict
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        output up_down,
        output up_evt,
        output dn_evt,
        output dir_chg,
        output conflict
    );
endinterface

// File: rtl/updown_btn_ctrl.sv
// Up/down pushbutton front end: per-button 2-flop sync, debounce and press detect,
// feeding a registered direction level plus one-cycle event pulses for the mod-N counter.
module updown_btn_ctrl #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned DB_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    updown_btn_ctrl_if.slave   bus
);

    localparam int unsigned NBTN   = 2;
    localparam int unsigned IDX_UP = 0;
    localparam int unsigned IDX_DN = 1;
    localparam logic [DB_W-1:0] DB_TARGET = DB_W'(DB_CYCLES);
    localparam logic [DB_W-1:0] CNT_ONE   = DB_W'(1);

    logic [NBTN-1:0] raw_c;

    logic [NBTN-1:0] s1_q, s1_d;
    logic [NBTN-1:0] s2_q, s2_d;
    logic [NBTN-1:0] deb_q, deb_d;
    logic [NBTN-1:0] deb_prev_q, deb_prev_d;
    logic [DB_W-1:0] cnt_q [NBTN];
    logic [DB_W-1:0] cnt_d [NBTN];
    logic [NBTN-1:0] press_c;

    logic up_down_q,  up_down_d;
    logic up_evt_q,   up_evt_d;
    logic dn_evt_q,   dn_evt_d;
    logic dir_chg_q,  dir_chg_d;
    logic conflict_q, conflict_d;

    assign raw_c[IDX_UP] = bus.btn_up;
    assign raw_c[IDX_DN] = bus.btn_down;

    // Two-stage synchroniser; only s2 is used downstream.
    always_comb begin
        s1_d = raw_c;
        s2_d = s1_q;
    end

    // Debounce: a mismatch must persist DB_CYCLES edges in a row before deb follows s2.
    always_comb begin
        deb_d = deb_q;
        for (int unsigned i = 0; i < NBTN; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                if ((cnt_q[i] + CNT_ONE) == DB_TARGET) begin
                    deb_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Rising edge of the debounced level is a press; releases are ignored.
    always_comb begin
        deb_prev_d = deb_q;
        press_c    = deb_q & ~deb_prev_q;
    end

    // Direction and event stage; simultaneous presses are reported but change nothing.
    always_comb begin
        up_down_d  = up_down_q;
        up_evt_d   = 1'b0;
        dn_evt_d   = 1'b0;
        dir_chg_d  = 1'b0;
        conflict_d = 1'b0;
        unique case (press_c)
            2'b01: begin
                up_evt_d  = 1'b1;
                up_down_d = 1'b1;
                dir_chg_d = ~up_down_q;
            end
            2'b10: begin
                dn_evt_d  = 1'b1;
                up_down_d = 1'b0;
                dir_chg_d = up_down_q;
            end
            2'b11: begin
                conflict_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int unsigned i = 0; i < NBTN; i++) begin
                cnt_q[i] <= '0;
            end
            up_down_q  <= 1'b0;
            up_evt_q   <= 1'b0;
            dn_evt_q   <= 1'b0;
            dir_chg_q  <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            for (int unsigned i = 0; i < NBTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            up_down_q  <= up_down_d;
            up_evt_q   <= up_evt_d;
            dn_evt_q   <= dn_evt_d;
            dir_chg_q  <= dir_chg_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.up_down  = up_down_q;
    assign bus.up_evt   = up_evt_q;
    assign bus.dn_evt   = dn_evt_q;
    assign bus.dir_chg  = dir_chg_q;
    assign bus.conflict = conflict_q;

endmodule
